// File: rtl/pll_phase_sequencer_if.sv
// Purpose: bundles the command-side request/status and PLL reconfiguration ports of the phase sequencer.
// Latency: none, wires only.
// Backpressure: none; a request is a one-cycle strobe and busy tells the requester the block is working.
interface pll_phase_sequencer_if;
    // Command processor side
    logic       updatepll;
    logic       pll_clk_src;
    logic [7:0] pll_clk_phase;
    logic       busy;
    logic [7:0] current_phase;
    logic       current_src;
    logic       error;
    // PLL reconfiguration side
    logic       activeclock;
    logic       phasedone;
    logic       scanclk;
    logic [2:0] phasecounterselect;
    logic       phaseupdown;
    logic       phasestep;
    logic       clkswitch;

    // Sequencer view
    modport master (
        input  updatepll, pll_clk_src, pll_clk_phase, activeclock, phasedone,
        output busy, current_phase, current_src, error,
               scanclk, phasecounterselect, phaseupdown, phasestep, clkswitch
    );

    // Environment view: command processor plus PLL
    modport slave (
        output updatepll, pll_clk_src, pll_clk_phase, activeclock, phasedone,
        input  busy, current_phase, current_src, error,
               scanclk, phasecounterselect, phaseupdown, phasestep, clkswitch
    );
endinterface

// File: rtl/pll_phase_sequencer.sv
// Purpose: walks the PLL input-clock switch and phase-step handshake until it matches the requested src/phase.
// Latency: busy one cycle after updatepll; each phase step spans 2 scanclk periods plus the phasedone round trip.
// Backpressure: one-deep pending slot; a strobe while busy overwrites it and is served right after IDLE.
module pll_phase_sequencer #(
    parameter int       SCAN_DIV       = 4,      // clk cycles per scanclk half-period, >= 2
    parameter logic [2:0] COUNTER_SEL  = 3'b000,
    parameter int       SWITCH_CYCLES  = 8,
    parameter int       TIMEOUT_CYCLES = 4096
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    pll_phase_sequencer_if.master  if_seq
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SRC_CHECK,
        S_SWITCH,
        S_SWITCH_WAIT,
        S_PH_CHECK,
        S_STEP_ARM,
        S_STEP_HOLD,
        S_STEP_DONE,
        S_ABORT
    } state_t;

    localparam int SD_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + SWITCH_CYCLES + 4 * SCAN_DIV + 2);

    localparam logic [SD_W-1:0]  SD_LAST  = SD_W'(SCAN_DIV - 1);
    localparam logic [TMR_W-1:0] SW_LAST  = TMR_W'(SWITCH_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    // Minimum STEP_ARM dwell so a new phaseupdown settles a full half-period before phasestep rises
    localparam logic [TMR_W-1:0] ARM_MIN  = TMR_W'(SCAN_DIV - 1);

    state_t            r_state;
    state_t            w_next;
    logic [SD_W-1:0]   r_scan_cnt;
    logic              r_scanclk;
    logic              r_pd_meta;
    logic              r_pd_sync;
    logic [TMR_W-1:0]  r_tmr;
    logic [1:0]        r_rise_cnt;
    logic              r_pd_low_seen;
    logic              r_arm_guard;
    logic              r_tgt_src;
    logic [7:0]        r_tgt_phase;
    logic              r_pend_vld;
    logic              r_pend_src;
    logic [7:0]        r_pend_phase;
    logic              r_cur_src;
    logic [7:0]        r_cur_phase;
    logic              r_err;
    logic              r_phaseupdown;
    logic              r_phasestep;
    logic              r_clkswitch;

    logic              w_scan_tick;
    logic              w_scan_rise;
    logic              w_scan_fall;
    logic              w_tmo;
    logic              w_dir;
    logic              w_start;
    logic              w_start_pend;
    logic              w_state_chg;

    assign w_scan_tick = (r_scan_cnt == SD_LAST);
    assign w_scan_rise = w_scan_tick & ~r_scanclk;
    assign w_scan_fall = w_scan_tick &  r_scanclk;
    assign w_tmo       = (r_tmr == TMO_LAST);
    assign w_dir       = (r_tgt_phase > r_cur_phase);
    assign w_state_chg = (w_next != r_state);

    // Free-running scanclk divider; ticks mark the cycle whose edge flips scanclk
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scan_cnt <= '0;
            r_scanclk  <= 1'b0;
        end else if (w_scan_tick) begin
            r_scan_cnt <= '0;
            r_scanclk  <= ~r_scanclk;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous phasedone; idles high like the PLL
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pd_meta <= 1'b1;
            r_pd_sync <= 1'b1;
        end else begin
            r_pd_meta <= if_seq.phasedone;
            r_pd_sync <= r_pd_meta;
        end
    end

    // Next-state decode; a waiting pending request takes priority over a fresh strobe in IDLE
    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_start_pend = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_vld) begin
                    w_next       = S_SRC_CHECK;
                    w_start      = 1'b1;
                    w_start_pend = 1'b1;
                end else if (if_seq.updatepll) begin
                    w_next  = S_SRC_CHECK;
                    w_start = 1'b1;
                end
            end
            S_SRC_CHECK:   w_next = (r_tgt_src != r_cur_src) ? S_SWITCH : S_PH_CHECK;
            S_SWITCH:      if (r_tmr == SW_LAST) w_next = S_SWITCH_WAIT;
            S_SWITCH_WAIT: begin
                if (if_seq.activeclock == r_tgt_src) w_next = S_PH_CHECK;
                else if (w_tmo)                      w_next = S_ABORT;
            end
            S_PH_CHECK:    w_next = (r_tgt_phase == r_cur_phase) ? S_IDLE : S_STEP_ARM;
            S_STEP_ARM: begin
                if (w_scan_fall && (!r_arm_guard || (r_tmr >= ARM_MIN))) w_next = S_STEP_HOLD;
            end
            S_STEP_HOLD: begin
                if (w_scan_fall && (r_rise_cnt == 2'd2)) w_next = S_STEP_DONE;
            end
            S_STEP_DONE: begin
                if (r_pd_low_seen && r_pd_sync) w_next = S_PH_CHECK;
                else if (w_tmo)                 w_next = S_ABORT;
            end
            S_ABORT:       w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    // State register plus per-state bookkeeping, request capture and registered PLL controls
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_rise_cnt    <= 2'd0;
            r_pd_low_seen <= 1'b0;
            r_arm_guard   <= 1'b0;
            r_tgt_src     <= 1'b0;
            r_tgt_phase   <= 8'd0;
            r_pend_vld    <= 1'b0;
            r_pend_src    <= 1'b0;
            r_pend_phase  <= 8'd0;
            r_cur_src     <= 1'b0;
            r_cur_phase   <= 8'd0;
            r_err         <= 1'b0;
            r_phaseupdown <= 1'b1;
            r_phasestep   <= 1'b0;
            r_clkswitch   <= 1'b0;
        end else begin
            r_state <= w_next;

            // Timer, rise counter and low-seen flag all restart on every state entry
            r_tmr <= w_state_chg ? '0 : r_tmr + 1'b1;
            if (w_state_chg)
                r_rise_cnt <= 2'd0;
            else if ((r_state == S_STEP_HOLD) && w_scan_rise && (r_rise_cnt != 2'd2))
                r_rise_cnt <= r_rise_cnt + 2'd1;
            if (w_state_chg)
                r_pd_low_seen <= 1'b0;
            else if ((r_state == S_STEP_DONE) && !r_pd_sync)
                r_pd_low_seen <= 1'b1;

            // Starting a sequence latches the target and clears the sticky error
            if (w_start) begin
                r_err <= 1'b0;
                if (w_start_pend) begin
                    r_tgt_src   <= r_pend_src;
                    r_tgt_phase <= r_pend_phase;
                end else begin
                    r_tgt_src   <= if_seq.pll_clk_src;
                    r_tgt_phase <= if_seq.pll_clk_phase;
                end
            end

            // A strobe that cannot start directly lands in the pending slot, newest wins
            if (if_seq.updatepll && ((r_state != S_IDLE) || r_pend_vld)) begin
                r_pend_vld   <= 1'b1;
                r_pend_src   <= if_seq.pll_clk_src;
                r_pend_phase <= if_seq.pll_clk_phase;
            end else if (w_start_pend) begin
                r_pend_vld <= 1'b0;
            end

            r_clkswitch <= (w_next == S_SWITCH);

            case (r_state)
                S_SWITCH_WAIT: if (w_next == S_PH_CHECK) r_cur_src <= r_tgt_src;
                S_PH_CHECK: begin
                    if (w_next == S_STEP_ARM) begin
                        r_phaseupdown <= w_dir;
                        r_arm_guard   <= (w_dir != r_phaseupdown);
                    end
                end
                S_STEP_ARM:  if (w_next == S_STEP_HOLD) r_phasestep <= 1'b1;
                S_STEP_HOLD: if (w_next == S_STEP_DONE) r_phasestep <= 1'b0;
                S_STEP_DONE: begin
                    if (w_next == S_PH_CHECK)
                        r_cur_phase <= r_phaseupdown ? r_cur_phase + 8'd1 : r_cur_phase - 8'd1;
                end
                default: ;
            endcase

            // Aborting leaves the tracked src/phase as they were and drops any request to the PLL
            if (w_next == S_ABORT) begin
                r_err       <= 1'b1;
                r_phasestep <= 1'b0;
            end
        end
    end

    assign if_seq.scanclk            = r_scanclk;
    assign if_seq.phasecounterselect = COUNTER_SEL;
    assign if_seq.phaseupdown        = r_phaseupdown;
    assign if_seq.phasestep          = r_phasestep;
    assign if_seq.clkswitch          = r_clkswitch;
    assign if_seq.busy               = (r_state != S_IDLE);
    assign if_seq.current_phase      = r_cur_phase;
    assign if_seq.current_src        = r_cur_src;
    assign if_seq.error              = r_err;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Purpose: directed bench for pll_phase_sequencer with a small PLL model and output monitors.
// Latency: inputs driven 1 ns after the rising edge, monitors sample on the falling edge.
// Backpressure: every wait is bounded by a cycle budget that counts as a check.
module tb_pll_phase_sequencer;

    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pll_phase_sequencer_if bus();

    pll_phase_sequencer #(
        .SCAN_DIV(SD), .COUNTER_SEL(3'b000), .SWITCH_CYCLES(8), .TIMEOUT_CYCLES(4096)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .if_seq (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // PLL model: phasedone pulses low 5..8 cycles after phasestep falls; activeclock flips 20 cycles after clkswitch rises
    logic pd_stuck = 1'b0;
    logic as_flip  = 1'b1;
    int   pd_cnt   = -1;
    int   sw_cnt   = -1;
    logic m_prev_step = 1'b0;
    logic m_prev_sw   = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            bus.phasedone   <= 1'b1;
            bus.activeclock <= 1'b0;
            pd_cnt          <= -1;
            sw_cnt          <= -1;
            m_prev_step     <= 1'b0;
            m_prev_sw       <= 1'b0;
        end else begin
            m_prev_step <= bus.phasestep;
            m_prev_sw   <= bus.clkswitch;
            if (m_prev_step && !bus.phasestep && !pd_stuck) pd_cnt <= 1;
            else if (pd_cnt >= 0) pd_cnt <= (pd_cnt == 9) ? -1 : pd_cnt + 1;
            if (pd_cnt == 5) bus.phasedone <= 1'b0;
            else if (pd_cnt == 9) bus.phasedone <= 1'b1;
            if (!m_prev_sw && bus.clkswitch && as_flip) sw_cnt <= 1;
            else if (sw_cnt >= 0) sw_cnt <= (sw_cnt == 20) ? -1 : sw_cnt + 1;
            if (sw_cnt == 20) bus.activeclock <= ~bus.activeclock;
        end
    end

    // Monitors: pulse counts, widths, direction settle time, scanclk half-period, busy cycles
    int   n_step_rise = 0, n_step_up = 0, n_step_badw = 0, step_w = 0;
    int   n_sw_rise = 0, sw_w = 0, sw_last_w = 0;
    int   busy_cycles = 0, n_busy_rise = 0;
    int   ud_age = 1000, n_dir_bad = 0;
    int   sc_age = -1, n_scan_bad = 0;
    logic p_step = 1'b0, p_sw = 1'b0, p_busy = 1'b0, p_ud = 1'b1, p_sc = 1'b0;
    always @(negedge clk) begin
        if (bus.phaseupdown !== p_ud) ud_age = 0;
        else if (ud_age < 1000) ud_age++;
        if (bus.phasestep && !p_step) begin
            n_step_rise++;
            step_w = 1;
            if (bus.phaseupdown) n_step_up++;
            if (ud_age < SD) n_dir_bad++;
        end else if (bus.phasestep) begin
            step_w++;
        end else if (p_step && !rst) begin
            if (step_w != 4 * SD) n_step_badw++;
        end
        if (bus.clkswitch && !p_sw) begin n_sw_rise++; sw_w = 1; end
        else if (bus.clkswitch) sw_w++;
        else if (p_sw) sw_last_w = sw_w;
        if (bus.busy) busy_cycles++;
        if (bus.busy && !p_busy) n_busy_rise++;
        if (rst) sc_age = -1;
        else if (bus.scanclk !== p_sc) begin
            if (sc_age != -1 && sc_age != SD) n_scan_bad++;
            sc_age = 1;
        end else if (sc_age != -1) sc_age++;
        p_step = bus.phasestep; p_sw = bus.clkswitch; p_busy = bus.busy;
        p_ud = bus.phaseupdown; p_sc = bus.scanclk;
    end

    task automatic req(input logic src, input logic [7:0] ph);
        bus.pll_clk_src   = src;
        bus.pll_clk_phase = ph;
        bus.updatepll     = 1'b1;
        @(posedge clk); #1;
        bus.updatepll     = 1'b0;
    endtask

    // Wait until busy has stayed low for 3 consecutive samples
    task automatic wait_quiet(input string tag, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (!bus.busy) quiet++; else quiet = 0;
        end
        check({tag, "_done"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},   32'(bus.busy), 32'd0);
        check({tag, "_step"},   32'(bus.phasestep), 32'd0);
        check({tag, "_sw"},     32'(bus.clkswitch), 32'd0);
        check({tag, "_updown"}, 32'(bus.phaseupdown), 32'd1);
        check({tag, "_phase"},  32'(bus.current_phase), 32'd0);
        check({tag, "_src"},    32'(bus.current_src), 32'd0);
        check({tag, "_err"},    32'(bus.error), 32'd0);
        check({tag, "_scan"},   32'(bus.scanclk), 32'd0);
        check({tag, "_csel"},   32'(bus.phasecounterselect), 32'd0);
    endtask

    int s_busy, s_step, s_up, s_badw, s_sw, s_brise, s_dir;

    task automatic snap();
        s_busy = busy_cycles; s_step = n_step_rise; s_up = n_step_up; s_badw = n_step_badw;
        s_sw = n_sw_rise; s_brise = n_busy_rise; s_dir = n_dir_bad;
    endtask

    initial begin
        bus.updatepll     = 1'b0;
        bus.pll_clk_src   = 1'b0;
        bus.pll_clk_phase = 8'd0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // No-op request: SRC_CHECK + PH_CHECK only
        snap();
        req(1'b0, 8'd0);
        check("noop_busy_n1", 32'(bus.busy), 32'd1);
        wait_quiet("noop", 100);
        check("noop_busy_cycles", 32'(busy_cycles - s_busy), 32'd2);
        check("noop_pulses", 32'((n_step_rise - s_step) + (n_sw_rise - s_sw)), 32'd0);
        check("noop_err", 32'(bus.error), 32'd0);

        // Step up 0 -> 3
        snap();
        req(1'b0, 8'd3);
        wait_quiet("up3", 2000);
        check("up3_pulses", 32'(n_step_rise - s_step), 32'd3);
        check("up3_dir_up", 32'(n_step_up - s_up), 32'd3);
        check("up3_width", 32'(n_step_badw - s_badw), 32'd0);
        check("up3_phase", 32'(bus.current_phase), 32'd3);
        check("up3_err", 32'(bus.error), 32'd0);

        // Step down 3 -> 1, direction must settle a half-period before the first step
        snap();
        req(1'b0, 8'd1);
        wait_quiet("dn1", 2000);
        check("dn1_pulses", 32'(n_step_rise - s_step), 32'd2);
        check("dn1_dir_up", 32'(n_step_up - s_up), 32'd0);
        check("dn1_dir_settle", 32'(n_dir_bad - s_dir), 32'd0);
        check("dn1_updown", 32'(bus.phaseupdown), 32'd0);
        check("dn1_phase", 32'(bus.current_phase), 32'd1);

        // Clock switch with a PLL that never answers: 1 + 8 + 4096 + 1 busy cycles
        as_flip = 1'b0;
        snap();
        req(1'b1, 8'd1);
        wait_quiet("swto", 6000);
        check("swto_busy_cycles", 32'(busy_cycles - s_busy), 32'd4106);
        check("swto_sw_width", 32'(sw_last_w), 32'd8);
        check("swto_err", 32'(bus.error), 32'd1);
        check("swto_src", 32'(bus.current_src), 32'd0);

        // Clock switch answered after 20 cycles; new request clears error
        as_flip = 1'b1;
        snap();
        req(1'b1, 8'd1);
        check("sw_err_clear", 32'(bus.error), 32'd0);
        wait_quiet("sw", 2000);
        check("sw_pulses", 32'(n_sw_rise - s_sw), 32'd1);
        check("sw_width", 32'(sw_last_w), 32'd8);
        check("sw_src", 32'(bus.current_src), 32'd1);
        check("sw_no_step", 32'(n_step_rise - s_step), 32'd0);

        // phasedone never drops: one step then abort, phase unchanged
        pd_stuck = 1'b1;
        snap();
        req(1'b1, 8'd2);
        wait_quiet("pdto", 6000);
        check("pdto_pulses", 32'(n_step_rise - s_step), 32'd1);
        check("pdto_err", 32'(bus.error), 32'd1);
        check("pdto_phase", 32'(bus.current_phase), 32'd1);
        check("pdto_step_low", 32'(bus.phasestep), 32'd0);
        pd_stuck = 1'b0;
        snap();
        req(1'b1, 8'd1);
        check("pdto_err_clear", 32'(bus.error), 32'd0);
        wait_quiet("pdto2", 100);
        check("pdto2_busy_cycles", 32'(busy_cycles - s_busy), 32'd2);

        // Pending slot: 3 runs, 5 is overwritten by 7, so only two sequences
        snap();
        req(1'b1, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        req(1'b1, 8'd5);
        repeat (2) @(posedge clk);
        #1;
        req(1'b1, 8'd7);
        wait_quiet("pend", 3000);
        check("pend_sequences", 32'(n_busy_rise - s_brise), 32'd2);
        check("pend_pulses", 32'(n_step_rise - s_step), 32'd6);
        check("pend_phase", 32'(bus.current_phase), 32'd7);
        check("pend_width", 32'(n_step_badw - s_badw), 32'd0);
        check("scan_half_period", 32'(n_scan_bad), 32'd0);

        // Reset in the middle of a step
        req(1'b1, 8'd0);
        begin
            int n = 0;
            while (!bus.phasestep && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            check("mid_step_seen", 32'(bus.phasestep), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midrst");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_phase_sequencer.md
# pll_phase_sequencer

Sequences the PLL's dynamic reconfiguration ports on behalf of the serial command processor. It consumes the one-cycle `updatepll` strobe and the requested `pll_clk_src` and `pll_clk_phase`. It then drives the clock-switch and phase-step handshake until the PLL's input clock and phase-step count match the request. It sits between the command processor and the PLL, generates its own `scanclk`, and reports progress and failures back as status.

## Interface
- SCAN_DIV, 4: clk cycles per scanclk half-period (≥2).
- COUNTER_SEL, 3'b000: phasecounterselect value (000 = all counters).
- SWITCH_CYCLES, 8: clk cycles clkswitch is held high.
- TIMEOUT_CYCLES, 4096: clk cycles allowed for activeclock / phasedone before abort.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- updatepll  in  1  one-cycle request strobe.
- pll_clk_src  in  1  requested input clock (0 = inclk0, 1 = inclk1).
- pll_clk_phase  in  8  requested absolute phase-step count.
- activeclock  in  1  PLL status: currently selected input.
- phasedone  in  1  PLL status: low while a step is in progress (asynchronous; 2-flop synchronized inside).
- scanclk  out  1  free-running, period 2*SCAN_DIV clk cycles.
- phasecounterselect  out  3  counter select.
- phaseupdown  out  1  1 = up, 0 = down.
- phasestep  out  1  step request.
- clkswitch  out  1  input-switch request.
- busy  out  1  high from request acceptance until sequence end.
- current_phase  out  8  phase-step count the PLL is at.
- current_src  out  1  input clock the PLL is on.
- error  out  1  sticky timeout flag.

## Operation
- Reset values: scanclk=0, phasecounterselect=COUNTER_SEL, phaseupdown=1, phasestep=0, clkswitch=0, busy=0, current_phase=0, current_src=0, error=0, pending cleared, FSM=IDLE.
- Reset mid-sequence aborts immediately. The PLL is reset by its own areset at the same time, so the 0/0 tracking state holds.
- scanclk toggles every SCAN_DIV clk cycles. It produces internal one-cycle ticks scan_rise and scan_fall.
- Request capture: on updatepll, latch target_src and target_phase. In IDLE the request starts the next cycle. Otherwise it is stored in a one-deep pending slot; a newer strobe overwrites the slot. The pending request starts on the cycle after the FSM returns to IDLE.
- Accepting a request clears error.
- States:
  - IDLE: busy=0. On request, go to SRC_CHECK.
  - SRC_CHECK: if target_src≠current_src, go to SWITCH; else go to PH_CHECK.
  - SWITCH: clkswitch=1 for SWITCH_CYCLES, then go to SWITCH_WAIT.
  - SWITCH_WAIT: when activeclock==target_src, set current_src=target_src and go to PH_CHECK. On timeout, go to ABORT.
  - PH_CHECK: if equal, go to IDLE. Otherwise set phaseupdown=(target_phase>current_phase) and go to STEP_ARM.
  - STEP_ARM: at the next scan_fall set phasestep=1, go to STEP_HOLD.
  - STEP_HOLD: hold phasestep through two scan_rise ticks. Clear it at the following scan_fall, go to STEP_DONE.
  - STEP_DONE: wait until synchronized phasedone has been seen low and then high. Then current_phase ±1 and go to PH_CHECK. On timeout, go to ABORT.
  - ABORT: error=1, clkswitch=0, phasestep=0. current_src/current_phase are left unchanged for the failed operation. Go to IDLE.
- Direction is chosen without wrap: target>current steps up by (target−current); otherwise it steps down by (current−target). Worst case is 255 steps.
- A changed request in the pending slot does not alter the sequence in progress.
- The timeout counter clears on every state entry.

## Timing
- updatepll at cycle N in IDLE: busy=1 at N+1, SRC_CHECK at N+1, target visible on current_* only after completion.
- phaseupdown is stable at least one full scanclk half-period before phasestep rises.
- phasestep changes only on scan_fall. It is high for exactly 2 scanclk periods (4*SCAN_DIV clk cycles).
- Per step, with immediate phasedone: ≤ 6*SCAN_DIV + 4 clk cycles.
- phasedone synchronizer adds 2 clk cycles to every observation.
- busy falls in the cycle the FSM enters IDLE. A pending request raises it again 1 cycle later.
- updatepll arriving on the same cycle the FSM enters IDLE goes to pending and is served next.

## Test plan
- Reset, then updatepll with src=0, phase=0 -> busy high for 2 cycles, no clkswitch or phasestep pulse, error=0.
- Request phase=3, PLL model asserts phasedone low 5 cycles after phasestep falls -> exactly 3 phasestep pulses, phaseupdown=1, each 16 clk wide (SCAN_DIV=4), current_phase=3.
- From phase=3, request phase=1 -> 2 pulses with phaseupdown=0 set before the first, current_phase=1.
- Request src=1, model flips activeclock 20 cycles after clkswitch -> clkswitch high 8 cycles, current_src=1. Model never flips -> ABORT after 4096 cycles, error=1, current_src=0.
- phasedone held high forever -> abort, error=1, current_phase unchanged. The next request clears error.
- Strobe phase=5 then phase=7 while busy -> after the first completes, one more sequence runs to 7; 5 is discarded. Reset asserted mid-step -> phasestep=0 and all outputs at reset values next cycle.
